// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity helper and legal parameter ranges.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int MIN_DATA_BITS    = 5;
  localparam int MAX_DATA_BITS    = 9;
  localparam int MIN_STOP_BITS    = 1;
  localparam int MAX_STOP_BITS    = 2;
  localparam int MIN_CLKS_PER_BIT = 4;

  // Even-parity bit of a payload; narrower payloads are zero-extended by the caller.
  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous level input; both flops reset to RESET_VAL.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= RESET_VAL;
      q        <= RESET_VAL;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver: mid-bit sampling, optional parity, 1/2 stop bits,
// one-entry output register with valid/ack handshake and overrun detection.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pin,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = 4;
  localparam int HALF = CLKS_PER_BIT / 2;

  if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS ||
      STOP_BITS < MIN_STOP_BITS || STOP_BITS > MAX_STOP_BITS ||
      CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_params
    $error("uart_rx_os: illegal parameter value");
  end

  logic                 pin_s;
  rx_state_t            state_reg, state_next;
  logic [CW-1:0]        cnt_reg;
  logic [IW-1:0]        bit_idx_reg;
  logic                 stop_idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 ferr_reg, perr_reg;
  logic                 done_reg;
  logic                 sample_pt;
  logic                 last_data, last_stop;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pin),
    .q     (pin_s)
  );

  // The start bit is sampled half a bit in; every later sample is one full bit after it.
  always_comb begin
    sample_pt = (state_reg == START) ? (cnt_reg == CW'(HALF - 1))
                                     : (cnt_reg == CW'(CLKS_PER_BIT - 1));
    last_data = (bit_idx_reg == IW'(DATA_BITS - 1));
    last_stop = (stop_idx_reg == 1'(STOP_BITS - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (!pin_s) state_next = START;
      START:     if (sample_pt) state_next = pin_s ? IDLE : DATA;
      DATA:      if (sample_pt && last_data) state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:    if (sample_pt) state_next = STOP;
      STOP:      if (sample_pt && last_stop) state_next = pin_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (pin_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      shift_reg    <= '0;
      ferr_reg     <= 1'b0;
      perr_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == IDLE || state_reg == WAIT_IDLE || sample_pt) cnt_reg <= '0;
      else                                                           cnt_reg <= cnt_reg + 1'b1;
      case (state_reg)
        START: begin
          bit_idx_reg  <= '0;
          stop_idx_reg <= 1'b0;
          ferr_reg     <= 1'b0;
          perr_reg     <= 1'b0;
        end
        DATA: if (sample_pt) begin
          shift_reg   <= {pin_s, shift_reg[DATA_BITS-1:1]};
          bit_idx_reg <= last_data ? '0 : bit_idx_reg + 1'b1;
        end
        PARITY: if (sample_pt) begin
          perr_reg <= (parity_of(MAX_DATA_BITS'(shift_reg)) ^ pin_s) != 1'(PARITY_ODD);
        end
        STOP: if (sample_pt) begin
          ferr_reg     <= ferr_reg | ~pin_s;
          stop_idx_reg <= last_stop ? 1'b0 : 1'b1;
          done_reg     <= last_stop;
        end
        default: ;
      endcase
    end
  end

  // Frame results are staged one clock in done_reg before they reach the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      data          <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
      overrun       <= 1'b0;
    end else if (done_reg && (!data_valid || rd_ack)) begin
      data          <= shift_reg;
      framing_error <= ferr_reg;
      parity_error  <= perr_reg;
      data_valid    <= 1'b1;
      overrun       <= 1'b0;
    end else if (done_reg) begin
      overrun <= 1'b1;
    end else if (rd_ack && data_valid) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: 8N1, 8E1 and 9-data/2-stop instances driven by a serial line model.
module tb_uart_rx_os;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pin [3];
  logic       ack [3];
  logic [7:0] data0, data1;
  logic [8:0] data2;
  logic       dv [3], fe [3], pe [3], ov [3], bz [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = -1;
  logic dv0_q = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) begin
    if (dv[0] && !dv0_q) rise_cyc = cyc;
    dv0_q = dv[0];
  end

  uart_rx_os #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .pin(pin[0]), .rd_ack(ack[0]), .data(data0), .data_valid(dv[0]),
    .framing_error(fe[0]), .parity_error(pe[0]), .overrun(ov[0]), .busy(bz[0]));

  uart_rx_os #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .pin(pin[1]), .rd_ack(ack[1]), .data(data1), .data_valid(dv[1]),
    .framing_error(fe[1]), .parity_error(pe[1]), .overrun(ov[1]), .busy(bz[1]));

  uart_rx_os #(.DATA_BITS(9), .CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_9n2 (
    .clk(clk), .reset(reset), .pin(pin[2]), .rd_ack(ack[2]), .data(data2), .data_valid(dv[2]),
    .framing_error(fe[2]), .parity_error(pe[2]), .overrun(ov[2]), .busy(bz[2]));

  typedef struct {
    logic [7:0] d;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [8:0] get_data(input int i);
    case (i)
      0:       return {1'b0, data0};
      1:       return {1'b0, data1};
      default: return data2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bits(input int inst, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      pin[inst] = bits[i];
      tick(C);
    end
  endtask

  // Line model: start bit, data LSB first, optional parity bit, then stop bits (stops[0] first).
  task automatic send_frame(input int inst, input logic [8:0] d, input int nd, input int has_par,
                            input logic pbit, input logic [1:0] stops, input int nstop);
    logic [15:0] bits;
    int n;
    bits = '0;
    n = 1;
    for (int i = 0; i < nd; i++) begin bits[n] = d[i]; n++; end
    if (has_par != 0) begin bits[n] = pbit; n++; end
    for (int s = 0; s < nstop; s++) begin bits[n] = stops[s]; n++; end
    drive_bits(inst, bits, n);
  endtask

  task automatic wait_valid(input int inst, input string name);
    int t;
    t = 0;
    while (!dv[inst] && t < 400) begin tick(1); t++; end
    checks++;
    if (!dv[inst]) begin
      errors++;
      $display("FAIL %s timeout actual=data_valid 0 expected=data_valid 1", name);
    end
  endtask

  task automatic check_frame(input int inst, input string name, input logic [8:0] exp_d,
                             input logic exp_fe, input logic exp_pe);
    wait_valid(inst, name);
    chk({name, "_data"}, 32'(get_data(inst)), 32'(exp_d));
    chk({name, "_ferr"}, 32'(fe[inst]), 32'(exp_fe));
    chk({name, "_perr"}, 32'(pe[inst]), 32'(exp_pe));
    $display("frame %s inst=%0d data=%0h ferr=%0b perr=%0b ovr=%0b", name, inst,
             get_data(inst), fe[inst], pe[inst], ov[inst]);
  endtask

  task automatic do_ack(input int inst);
    ack[inst] = 1'b1;
    tick(1);
    ack[inst] = 1'b0;
    chk("ack_clears_valid", 32'(dv[inst]), 32'd0);
  endtask

  initial begin
    int start_cyc;
    logic [7:0] rd;
    logic rs, rp;

    tbl[0] = '{8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    tbl[1] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    tbl[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
    tbl[5] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1};
    tbl[6] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[7] = '{8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};

    for (int i = 0; i < 3; i++) begin pin[i] = 1'b1; ack[i] = 1'b0; end
    reset = 1'b1;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      chk("reset_data", 32'(get_data(i)), 32'd0);
      chk("reset_valid", 32'(dv[i]), 32'd0);
      chk("reset_flags", {29'd0, fe[i], pe[i], ov[i]}, 32'd0);
      chk("reset_busy", 32'(bz[i]), 32'd0);
    end
    reset = 1'b0;
    tick(2);

    // 8N1 frame latency from the falling edge: 2 sync + 1 detect + C/2 + 9*C + 1
    start_cyc = cyc;
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1);
    chk("latency_a5", 32'(rise_cyc - start_cyc), 32'(3 + C / 2 + 9 * C + 1));
    check_frame(0, "a5", 9'h0A5, 1'b0, 1'b0);
    do_ack(0);
    tick(4);

    // False start: four low clocks then high
    pin[0] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      if (k == 4) pin[0] = 1'b1;
      if (k == 3) chk("false_start_busy_on", 32'(bz[0]), 32'd1);
      if (k == 11) chk("false_start_busy_off", 32'(bz[0]), 32'd0);
    end
    chk("false_start_no_valid", 32'(dv[0]), 32'd0);

    // Broken stop bit followed by a held-low line
    send_frame(0, 9'h03C, 8, 0, 1'b0, 2'b00, 1);
    check_frame(0, "3c_break", 9'h03C, 1'b1, 1'b0);
    do_ack(0);
    for (int k = 0; k < 40; k++) begin
      tick(1);
      chk("break_busy", 32'(bz[0]), 32'd1);
      chk("break_no_frame", 32'(dv[0]), 32'd0);
    end
    pin[0] = 1'b1;
    tick(5);
    chk("break_released_busy", 32'(bz[0]), 32'd0);
    chk("break_released_valid", 32'(dv[0]), 32'd0);

    // Overrun: second frame arrives while the first is still held
    send_frame(0, 9'h011, 8, 0, 1'b0, 2'b11, 1);
    send_frame(0, 9'h022, 8, 0, 1'b0, 2'b11, 1);
    chk("ovr_valid", 32'(dv[0]), 32'd1);
    chk("ovr_data", 32'(data0), 32'h11);
    chk("ovr_flag", 32'(ov[0]), 32'd1);
    $display("frame ovr inst=0 data=%0h ovr=%0b", data0, ov[0]);
    do_ack(0);
    chk("ovr_cleared", 32'(ov[0]), 32'd0);
    tick(3);

    // Ack in the completion clock of the second frame
    send_frame(0, 9'h011, 8, 0, 1'b0, 2'b11, 1);
    fork
      send_frame(0, 9'h022, 8, 0, 1'b0, 2'b11, 1);
      begin
        tick(3 + C / 2 + 9 * C);
        ack[0] = 1'b1;
        tick(1);
        ack[0] = 1'b0;
      end
    join
    chk("same_clk_valid", 32'(dv[0]), 32'd1);
    chk("same_clk_data", 32'(data0), 32'h22);
    chk("same_clk_ovr", 32'(ov[0]), 32'd0);
    $display("frame same_clk inst=0 data=%0h ovr=%0b", data0, ov[0]);
    do_ack(0);
    tick(3);

    // Table of 8E1 frames
    for (int i = 0; i < 8; i++) begin
      send_frame(1, {1'b0, tbl[i].d}, 8, 1, tbl[i].pbit, {1'b1, tbl[i].stop}, 1);
      check_frame(1, $sformatf("tbl%0d", i), {1'b0, tbl[i].exp_d}, tbl[i].exp_fe, tbl[i].exp_pe);
      do_ack(1);
      pin[1] = 1'b1;
      tick(4);
    end

    // Random 8N1 frames against the line model
    for (int i = 0; i < 20; i++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(0, {1'b0, rd}, 8, 0, 1'b0, {1'b1, rs}, 1);
      check_frame(0, $sformatf("rnd8n1_%0d", i), {1'b0, rd}, ~rs, 1'b0);
      chk("rnd8n1_ovr", 32'(ov[0]), 32'd0);
      do_ack(0);
      pin[0] = 1'b1;
      tick($urandom_range(2, 20));
    end

    // Random 8E1 frames: parity error whenever the ones count including pbit is odd
    for (int i = 0; i < 16; i++) begin
      rd = 8'($urandom);
      rp = 1'($urandom);
      send_frame(1, {1'b0, rd}, 8, 1, rp, 2'b11, 1);
      check_frame(1, $sformatf("rnd8e1_%0d", i), {1'b0, rd}, 1'b0, (^rd) ^ rp);
      do_ack(1);
      tick($urandom_range(2, 20));
    end

    // 9-bit, 2 stop: reset mid-DATA while an earlier frame is still held
    send_frame(2, 9'h155, 9, 0, 1'b0, 2'b11, 2);
    check_frame(2, "9n2_155", 9'h155, 1'b0, 1'b0);
    drive_bits(2, 16'b1010_1100_1010_0110, 4);
    chk("9n2_busy_mid", 32'(bz[2]), 32'd1);
    reset = 1'b1;
    tick(1);
    chk("9n2_rst_busy", 32'(bz[2]), 32'd0);
    chk("9n2_rst_data", 32'(data2), 32'd0);
    chk("9n2_rst_flags", {28'd0, dv[2], fe[2], pe[2], ov[2]}, 32'd0);
    reset = 1'b0;
    pin[2] = 1'b1;
    tick(20);
    chk("9n2_no_partial", 32'(dv[2]), 32'd0);
    send_frame(2, 9'h1FF, 9, 0, 1'b0, 2'b11, 2);
    check_frame(2, "9n2_1ff", 9'h1FF, 1'b0, 1'b0);
    do_ack(2);
    send_frame(2, 9'h0A3, 9, 0, 1'b0, 2'b01, 2);
    check_frame(2, "9n2_stop2_bad", 9'h0A3, 1'b1, 1'b0);
    do_ack(2);
    pin[2] = 1'b1;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
